// File: rtl/i2c_pkg.sv
// Shared I2C E2PROM definitions: phase codes, default phase lengths, ACK sample point
// and R/W polarity. Also used by the data-processing datapath.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_START = 3'b001,
    ST_CHIP  = 3'b010,
    ST_REG   = 3'b011,
    ST_DSEND = 3'b100,
    ST_DRCV  = 3'b101,
    ST_STOP  = 3'b110
  } state_t;

  localparam int unsigned START_LEN_DEF  = 40;
  localparam int unsigned BYTE_LEN_DEF   = 225;
  localparam int unsigned STOP_LEN_DEF   = 40;
  localparam int unsigned ACK_SAMPLE_DEF = 221;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_phase_timer.sv
// Per-phase clock timer: counts up from 0, clears on request, flags the last
// cycle of a phase of length i_len.
module i2c_phase_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic [7:0] i_len,
  output logic [7:0] o_count,
  output logic       o_tc
);

  logic [7:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_count <= '0;
    else if (i_clr) r_count <= '0;
    else            r_count <= r_count + 8'd1;
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_len - 8'd1);

endmodule

// File: rtl/i2c_master_seq.sv
// I2C E2PROM master sequencer: bus-phase FSM, byte counting, ACK checking.
// Optional NACK retry (up to 3 retries) when I2C_NACK_RETRY_EN is defined.
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int START_LEN  = START_LEN_DEF,
  parameter int BYTE_LEN   = BYTE_LEN_DEF,
  parameter int STOP_LEN   = STOP_LEN_DEF,
  parameter int ACK_SAMPLE = ACK_SAMPLE_DEF
) (
  input  logic       i_clk10MHz,
  input  logic       i_RST_n,
  input  logic       i_Enable,
  input  logic       i_R_W,
  input  logic [7:0] i_Data_Num,
  input  logic       i_SDA_In,
  output logic [2:0] o_Current_State,
  output logic [7:0] o_Clock_Timer,
  output logic       o_Read_Setting_Flag,
  output logic       o_Busy,
  output logic       o_Data_Req,
  output logic       o_Byte_Done,
  output logic       o_Done,
  output logic       o_Err
);

  state_t     r_state, w_next;
  logic       r_rw, r_flag, r_nack, r_fail;
  logic [7:0] r_num, r_cnt;
  logic       r_data_req, r_byte_done, r_done, r_err;
  logic [7:0] w_len, w_timer;
  logic       w_tc, w_clr, w_accept, w_last, w_ack_chk, w_retry_ok;
  logic       w_pre_end, w_data_req, w_byte_done;

  i2c_phase_timer u_timer (
    .i_clk   (i_clk10MHz),
    .i_rst_n (i_RST_n),
    .i_clr   (w_clr),
    .i_len   (w_len),
    .o_count (w_timer),
    .o_tc    (w_tc)
  );

  assign w_accept  = (r_state == ST_IDLE) && i_Enable;
  assign w_last    = (r_cnt + 8'd1 == r_num);
  assign w_ack_chk = (r_state == ST_CHIP) || (r_state == ST_REG) || (r_state == ST_DSEND);
  // Timer restarts at every phase boundary, including back-to-back byte phases.
  assign w_clr     = (r_state == ST_IDLE) || w_tc;
  // Pulses are registered one cycle early so they appear while the timer reads BYTE_LEN-1.
  assign w_pre_end = (w_timer == 8'(BYTE_LEN - 2));

`ifdef I2C_NACK_RETRY_EN
  logic [1:0] r_retry;
  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n)  r_retry <= '0;
    else if (w_accept) r_retry <= '0;
    else if (r_state == ST_STOP && w_tc && r_fail && w_next == ST_START)
      r_retry <= r_retry + 2'd1;
  end
  assign w_retry_ok = (r_retry != 2'd3);
`else
  assign w_retry_ok = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_len       = 8'(BYTE_LEN);
    w_data_req  = 1'b0;
    w_byte_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_len = 8'(START_LEN);
        if (i_Enable) w_next = ST_START;
      end
      ST_START: begin
        w_len = 8'(START_LEN);
        if (w_tc) w_next = ST_CHIP;
      end
      ST_CHIP: if (w_tc) w_next = r_nack ? ST_STOP : (r_flag ? ST_DRCV : ST_REG);
      ST_REG: begin
        w_data_req = w_pre_end && !r_nack && (r_rw == RW_WRITE);
        if (w_tc) w_next = r_nack ? ST_STOP : ((r_rw == RW_READ) ? ST_START : ST_DSEND);
      end
      ST_DSEND: begin
        w_data_req  = w_pre_end && !r_nack && !w_last;
        w_byte_done = w_pre_end;
        if (w_tc) w_next = (r_nack || w_last) ? ST_STOP : ST_DSEND;
      end
      ST_DRCV: begin
        w_byte_done = w_pre_end;
        if (w_tc) w_next = w_last ? ST_STOP : ST_DRCV;
      end
      ST_STOP: begin
        w_len = 8'(STOP_LEN);
        if (w_tc) w_next = (r_fail && w_retry_ok) ? ST_START : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state     <= ST_IDLE;
      r_rw        <= 1'b0;
      r_num       <= '0;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
      r_nack      <= 1'b0;
      r_fail      <= 1'b0;
      r_data_req  <= 1'b0;
      r_byte_done <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_data_req  <= w_data_req;
      r_byte_done <= w_byte_done;
      r_done      <= 1'b0;
      if (w_accept) begin
        r_rw   <= i_R_W;
        r_num  <= (i_Data_Num == 8'd0) ? 8'd1 : i_Data_Num;
        r_cnt  <= '0;
        r_flag <= 1'b0;
        r_nack <= 1'b0;
        r_fail <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_ack_chk && w_timer == 8'(ACK_SAMPLE)) r_nack <= i_SDA_In;
        else if (w_tc)                             r_nack <= 1'b0;
        if (w_tc && (r_state == ST_DSEND || r_state == ST_DRCV)) r_cnt <= r_cnt + 8'd1;
        if (w_tc && w_ack_chk && r_nack) r_fail <= 1'b1;
        if (w_tc && r_state == ST_REG && w_next == ST_START) r_flag <= 1'b1;
        if (r_state == ST_STOP && w_tc) begin
          if (!r_fail) r_done <= 1'b1;
          else if (w_next == ST_START) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
            r_fail <= 1'b0;
          end else r_err <= 1'b1;
        end
        if (w_next == ST_IDLE) r_flag <= 1'b0;
      end
    end
  end

  assign o_Current_State     = r_state;
  assign o_Clock_Timer       = w_timer;
  assign o_Read_Setting_Flag = r_flag;
  assign o_Busy              = (r_state != ST_IDLE);
  assign o_Data_Req          = r_data_req;
  assign o_Byte_Done         = r_byte_done;
  assign o_Done              = r_done;
  assign o_Err               = r_err;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: table-driven and random transactions checked against a
// phase-list model; hand sequences for reset state and asynchronous mid-transfer reset.
module tb_i2c_master_seq;

`ifdef I2C_NACK_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, rw = 1'b0, sda = 1'b0;
  logic [7:0] num = 8'd0;
  logic [2:0] st;
  logic [7:0] tmr;
  logic       flag, busy, dreq, bdone, done, err;

  always #50 clk = ~clk;

  i2c_master_seq dut (
    .i_clk10MHz(clk), .i_RST_n(rst_n), .i_Enable(en), .i_R_W(rw),
    .i_Data_Num(num), .i_SDA_In(sda), .o_Current_State(st), .o_Clock_Timer(tmr),
    .o_Read_Setting_Flag(flag), .o_Busy(busy), .o_Data_Req(dreq),
    .o_Byte_Done(bdone), .o_Done(done), .o_Err(err)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: expected phase list (state codes), busy cycles and pulse counts.
  int exp_q[$];
  int e_cyc, e_dreq, e_bd, e_done, e_err;

  task automatic push(input int s);
    exp_q.push_back(s);
    e_cyc += (s == 1 || s == 6) ? 40 : 225;
  endtask

  task automatic model(input bit m_rw, input int n, input bit [3:0] mask, input int kind);
    int neff;
    int atts;
    neff = (n == 0) ? 1 : n;
    atts = RETRY ? 4 : 1;
    exp_q.delete();
    e_cyc = 0; e_dreq = 0; e_bd = 0; e_done = 0; e_err = 0;
    for (int a = 0; a < atts; a++) begin
      push(1); push(2);
      if (mask[a] && kind == 1) begin push(6); if (a == atts - 1) e_err = 1; continue; end
      push(3);
      if (mask[a] && kind == 2) begin push(6); if (a == atts - 1) e_err = 1; continue; end
      if (m_rw) begin
        push(1); push(2);
        for (int b = 0; b < neff; b++) push(5);
      end else begin
        for (int b = 0; b < neff; b++) push(4);
        e_dreq = neff;
      end
      e_bd = neff;
      push(6);
      e_done = 1;
      break;
    end
  endtask

  typedef struct {
    bit       rw;
    int       n;
    bit [3:0] mask;
    int       kind;
    bit       hold;
    int       exp_cyc;
  } vec_t;

  task automatic run_txn(input bit t_rw, input int n, input bit [3:0] mask, input int kind,
                         input bit hold, input int exp_cyc, input string tag);
    int obs[$];
    int cyc, c_dreq, c_bd, c_done, badt, att;
    bit seq_ok;
    cyc = 0; c_dreq = 0; c_bd = 0; c_done = 0; badt = 0; att = -1;
    model(t_rw, n, mask, kind);
    @(negedge clk);
    en = 1'b1; rw = t_rw; num = n[7:0]; sda = 1'b0;
    @(negedge clk);
    if (!hold) en = 1'b0;
    chk({tag, " accept->Start"}, {st, tmr}, {3'd1, 8'd0});
    while (busy && cyc < 20000) begin
      cyc++;
      if (tmr == 8'd0) begin
        obs.push_back(int'(st));
        if (st == 3'd2 && !flag) att++;
      end
      if (dreq)  c_dreq++;
      if (bdone) c_bd++;
      if (done)  c_done++;
      if ((dreq || bdone) && tmr != 8'd224) badt++;
      sda = (att >= 0 && att < 4 && mask[att] &&
             ((kind == 1 && st == 3'd2 && !flag) || (kind == 2 && st == 3'd3)));
      @(negedge clk);
    end
    en = 1'b0;
    sda = 1'b0;
    seq_ok = (obs.size() == exp_q.size());
    if (seq_ok) foreach (obs[i]) if (obs[i] != exp_q[i]) seq_ok = 1'b0;
    chk({tag, " phase-seq"}, int'(seq_ok), 1);
    chk({tag, " busy-cycles"}, cyc, (exp_cyc != 0) ? exp_cyc : e_cyc);
    chk({tag, " data-req-count"}, c_dreq, e_dreq);
    chk({tag, " byte-done-count"}, c_bd, e_bd);
    chk({tag, " pulse-timing"}, badt, 0);
    chk({tag, " done-at-idle"}, {c_done, done}, {32'd0, e_done[0]});
    chk({tag, " err"}, int'(err), e_err);
    chk({tag, " flag-at-idle"}, int'(flag), 0);
    @(negedge clk);
    chk({tag, " idle-after"}, {busy, done, err}, {2'b00, e_err[0]});
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{rw: 1'b0, n: 2, mask: 4'b0000, kind: 0, hold: 1'b0, exp_cyc: 980};
    tbl[1] = '{rw: 1'b1, n: 1, mask: 4'b0000, kind: 0, hold: 1'b0, exp_cyc: 1020};
    tbl[2] = '{rw: 1'b0, n: 1, mask: 4'b0000, kind: 0, hold: 1'b0, exp_cyc: 755};
    tbl[3] = '{rw: 1'b0, n: 0, mask: 4'b0000, kind: 0, hold: 1'b1, exp_cyc: 755};
    tbl[4] = '{rw: 1'b0, n: 1, mask: 4'b1111, kind: 1, hold: 1'b0, exp_cyc: 0};
    tbl[5] = '{rw: 1'b0, n: 1, mask: 4'b0001, kind: 1, hold: 1'b0, exp_cyc: 0};
    tbl[6] = '{rw: 1'b1, n: 2, mask: 4'b0001, kind: 2, hold: 1'b0, exp_cyc: 0};
    tbl[7] = '{rw: 1'b1, n: 3, mask: 4'b0000, kind: 0, hold: 1'b0, exp_cyc: 1470};

    #120;
    chk("reset-outputs", {st, tmr, flag, busy, dreq, bdone, done, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle-after-reset", {st, tmr, busy}, 0);

    foreach (tbl[i])
      run_txn(tbl[i].rw, tbl[i].n, tbl[i].mask, tbl[i].kind, tbl[i].hold,
              tbl[i].exp_cyc, $sformatf("tbl%0d", i));

    begin : mid_reset
      int w;
      w = 0;
      @(negedge clk);
      en = 1'b1; rw = 1'b0; num = 8'd2;
      @(negedge clk);
      en = 1'b0;
      while (!(st == 3'd4 && tmr == 8'd100) && w < 3000) begin
        @(negedge clk);
        w++;
      end
      chk("reach-datasend-t100", int'(w < 3000), 1);
      #10 rst_n = 1'b0;
      #1;
      chk("async-reset-mid", {st, tmr, flag, busy, dreq, bdone, done, err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_txn(1'b0, 1, 4'b0000, 0, 1'b0, 755, "post-reset");

    for (int r = 0; r < 6; r++)
      run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
              4'($urandom_range(0, 15)), int'($urandom_range(1, 2)),
              1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", r));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_seq.md
# i2c_master_seq

Sequencing controller for the I2C E2PROM master. It owns the bus-phase state register and the per-phase clock timer that drive the I2C data-processing datapath (`i_Current_State`, `Clock_Timer`, `o_Read_Setting_Flag`). It accepts one host transaction at a time: an n-byte write, or a random-address n-byte read with repeated start. It counts bytes, checks slave ACKs, and reports completion or error.

## Interface
Parameters:
- `START_LEN`, 40: clocks spent in Start.
- `BYTE_LEN`, 225: clocks per byte phase (9 SCL periods of 25 clocks).
- `STOP_LEN`, 40: clocks spent in Stop.
- `ACK_SAMPLE`, 221: timer value at which the slave ACK is sampled.

Ports:
- `i_clk10MHz` in 1: the single clock, 10 MHz.
- `i_RST_n` in 1: asynchronous, active-low reset.
- `i_Enable` in 1: transaction request; sampled only in Idle.
- `i_R_W` in 1: 1 = read, 0 = write; latched on accept.
- `i_Data_Num` in 8: byte count; latched on accept.
- `i_SDA_In` in 1: resolved SDA line level.
- `o_Current_State` out 3: phase code to the datapath.
- `o_Clock_Timer` out 8: clocks elapsed in the current phase.
- `o_Read_Setting_Flag` out 1: E2PROM address pointer set; the next chip address goes out with R=1.
- `o_Busy` out 1: high whenever the state is not Idle.
- `o_Data_Req` out 1: one-cycle pulse; the host must present the next write byte.
- `o_Byte_Done` out 1: one-cycle pulse at the end of each Data_Send/Data_Rcv byte.
- `o_Done` out 1: one-cycle pulse on successful completion.
- `o_Err` out 1: sticky NACK failure flag; cleared on the next accept.

## Operation
State codes:
- Idle 000, Start 001, Chip_Addr_Send 010, Reg_Addr_Send 011, Data_Send 100, Data_Rcv 101, Stop 110.
- 111 is illegal and returns to Idle on the next cycle.

Transaction accept and count:
- Accept happens when the state is Idle and `i_Enable`=1. On accept, latch `i_R_W` and `i_Data_Num`, clear the byte count, clear `o_Read_Setting_Flag`, clear `o_Err`, clear the retry count, and go to Start.
- `i_Data_Num`=0 is treated as 1.

Write sequence:
- Start → Chip_Addr_Send → Reg_Addr_Send → Data_Send ×N → Stop → Idle.

Read sequence:
- Start → Chip_Addr_Send → Reg_Addr_Send → Start (repeated) → Chip_Addr_Send → Data_Rcv ×N → Stop → Idle.
- `o_Read_Setting_Flag` rises on the Reg_Addr_Send→Start transition. It stays high until Idle.
- The branch after Chip_Addr_Send goes to Data_Rcv if the flag is 1, otherwise to Reg_Addr_Send.

ACK check:
- In Chip_Addr_Send, Reg_Addr_Send and Data_Send, latch `i_SDA_In` at timer=`ACK_SAMPLE`. A latched 1 is a NACK.
- A NACK forces the next state to Stop, with the failure recorded.
- Data_Rcv is not checked (the master drives ACK).

Completion:
- After Stop completes, a successful transaction pulses `o_Done` on entering Idle.
- A failed transaction follows the Configuration rules.
- `i_Enable` changes during a transaction are ignored; there is no abort.

Byte count and write-data request:
- The byte counter is 8-bit and increments at the last cycle of each Data_Send/Data_Rcv.
- The phase exits to Stop when the count (after increment) equals the latched N.
- `o_Data_Req` pulses at the last cycle of Reg_Addr_Send and of every Data_Send that is followed by another Data_Send.

## Timing
Phase timer:
- `o_Clock_Timer` is 0 in the first cycle of every phase and increments each clock.
- The transition happens in the cycle where timer = LEN−1. Start spans timer 0..39, a byte phase 0..224, Stop 0..39.
- Idle holds the timer at 0.

Latencies:
- Accept → Start is 1 cycle: `i_Enable` sampled at edge k, and the state is Start at edge k+1.
- Total clocks for a write of N bytes: 40 + 225·(2+N) + 40. A 1-byte write is 755 cycles.
- Total clocks for a read: 40 + 450 + 40 + 225·(1+N) + 40.

Pulse timing:
- `o_Byte_Done` and `o_Data_Req` are asserted in the cycle where timer=224 and are registered.
- Read data is valid from the datapath when `o_Byte_Done` is high.

Reset values:
- Every output resets to 0; the state resets to Idle (which releases the bus).
- Reset asserted mid-transaction aborts immediately and asynchronously. No Stop condition is generated.

## Configuration
Macro `I2C_NACK_RETRY_EN`:
- Defined: after a NACK-terminated Stop, the controller re-enters Start with the byte count and flag cleared, while the retry count is below 3 (2-bit counter). On the 4th consecutive failure it goes to Idle with `o_Err`=1 and no `o_Done`.
- Undefined: the first NACK leads to Stop → Idle with `o_Err`=1.
- In both cases `o_Busy` stays high through retries.

## Structure
- Shared package `i2c_pkg`: the 3-bit state encodings, the default phase lengths (40/225/40), `ACK_SAMPLE`=221, and the R/W polarity constants (read=1, write=0).
- The same package is used by the data-processing datapath.
- One sub-module, `i2c_phase_timer`: an 8-bit counter with a clear-on-phase-change input and a terminal-count output, compared against a length input.

## Test plan
- Write, N=2, slave always ACKs: states 001,010,011,100,100,110,000. `o_Data_Req` gives 2 pulses. `o_Done` pulses at cycle 40+225·4+40=980 after Start entry.
- Read, N=1, ACKs: sequence 001,010,011,001,010,101,110,000. `o_Read_Setting_Flag` rises entering the second Start. `o_Byte_Done` pulses once, and the flag clears in Idle.
- SDA=1 at timer 221 of the first Chip_Addr_Send, macro undefined: next state is Stop, then Idle with `o_Err`=1 and no `o_Done`.
- Same NACK stimulus repeated on every attempt, macro defined: 4 Start entries, then Idle with `o_Err`=1. A NACK only on the first attempt, macro defined: the second attempt completes with `o_Done`.
- `i_RST_n` pulled low at timer 100 of Data_Send: all outputs are 0 and the state is Idle in the same cycle. A new `i_Enable` is accepted normally.
- `i_Data_Num`=0 write: exactly one Data_Send, then Stop. `i_Enable` held high during the transaction causes no re-accept until Idle.
